// File: rtl/gamepad_scanner.sv
// -----------------------------------------------------------------------------
// gamepad_scanner
//
// Scans up to four Genesis/Mega Drive style controller ports once per video
// frame. A frame starts on the falling edge of v_sync. The scanner walks the
// shared Select line through 8 phases (or 2 phases in 3-button mode), samples
// the pads at the end of each phase and then publishes debounced results.
//
// Parameters
//   NUM_PADS        number of pads sharing Select (1..4)
//   SETTLE_CYCLES   clock cycles per Select phase (>= 4)
//   DEBOUNCE_FRAMES identical consecutive scans needed to change a bit (1..4)
//
// Ports
//   Clock50    system clock, rising edge
//   Reset      synchronous, active-high
//   v_sync     active-low vertical sync; its falling edge starts a scan
//   Pins       raw active-low pad pins, 6 per pad {P9,P6,P4,P3,P2,P1}
//   ForceThree run the next scan in 3-button mode
//   Select     shared pad Select line
//   Buttons    debounced active-high buttons, 12 per pad
//              {Mode,X,Y,Z,Start,A,C,B,Right,Left,Down,Up}
//   Pressed    one-cycle pulse on a debounced 0->1 transition
//   Present    pad detected in the last scan
//   SixButton  pad identified as 6-button in the last scan
//   Valid      one-cycle pulse when results are published
//   Busy       high while Select is being sequenced
// -----------------------------------------------------------------------------
module gamepad_scanner #(
  parameter int NUM_PADS        = 2,
  parameter int SETTLE_CYCLES   = 500,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic                    Clock50,
  input  logic                    Reset,
  input  logic                    v_sync,
  input  logic [6*NUM_PADS-1:0]   Pins,
  input  logic                    ForceThree,
  output logic                    Select,
  output logic [12*NUM_PADS-1:0]  Buttons,
  output logic [12*NUM_PADS-1:0]  Pressed,
  output logic [NUM_PADS-1:0]     Present,
  output logic [NUM_PADS-1:0]     SixButton,
  output logic                    Valid,
  output logic                    Busy
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(SETTLE_CYCLES - 1);
  // History slots kept per bit; at least one so the array is never empty.
  localparam int HIST = (DEBOUNCE_FRAMES > 1) ? DEBOUNCE_FRAMES - 1 : 1;

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  // Synchronizers
  logic                        vs_meta_reg, vs_sync_reg, vs_prev_reg;
  logic [NUM_PADS-1:0][5:0]    pins_meta_reg, pins_sync_reg;

  // Sequencer
  state_t                      state_reg;
  logic [2:0]                  phase_reg;
  logic [CW-1:0]               cnt_reg;
  logic                        force_reg;
  logic                        select_reg;
  logic                        busy_reg;

  // Raw per-scan captures
  logic [NUM_PADS-1:0][11:0]   raw_btn_reg;
  logic [NUM_PADS-1:0]         raw_present_reg;
  logic [NUM_PADS-1:0]         raw_six_reg;

  // Published state
  logic [NUM_PADS-1:0][11:0]   btn_reg;
  logic [NUM_PADS-1:0][11:0]   pressed_reg;
  logic [NUM_PADS-1:0]         present_reg;
  logic [NUM_PADS-1:0]         six_reg;
  logic                        valid_reg;
  logic [NUM_PADS-1:0][HIST-1:0][11:0] hist_reg;

  // Debounce results, applied only in PUBLISH
  logic [NUM_PADS-1:0][11:0]   btn_next;
  logic [NUM_PADS-1:0][11:0]   pressed_next;
  logic [NUM_PADS-1:0][HIST-1:0][11:0] hist_next;

  logic vs_fall;
  logic last_phase;

  assign vs_fall    = vs_prev_reg & ~vs_sync_reg;
  assign last_phase = (phase_reg == 3'd7) || (force_reg && phase_reg == 3'd1);

  // ---------------------------------------------------------------------------
  // Per-pad debounce. A bit follows the new sample only when the sample
  // agrees with every stored history entry; otherwise the old value holds.
  // An absent pad clears both its buttons and its history outright.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    logic [11:0]           sample_next;
    logic [11:0]           stable_next;
    logic [11:0]           btn_pad_next;
    logic [11:0]           pressed_pad_next;
    logic [HIST-1:0][11:0] hist_pad_next;

    always_comb begin
      // Extended buttons mean nothing unless the pad proved to be 6-button.
      sample_next = {raw_btn_reg[gi][11:8] & {4{raw_six_reg[gi]}},
                     raw_btn_reg[gi][7:0]};
      stable_next = '1;
      for (int k = 0; k < DEBOUNCE_FRAMES - 1; k++) begin
        stable_next = stable_next & ~(hist_reg[gi][k] ^ sample_next);
      end
      hist_pad_next    = '0;
      hist_pad_next[0] = sample_next;
      for (int k = 1; k < HIST; k++) begin
        hist_pad_next[k] = hist_reg[gi][k-1];
      end
      btn_pad_next = (btn_reg[gi] & ~stable_next) | (sample_next & stable_next);
      if (!raw_present_reg[gi]) begin
        btn_pad_next  = '0;
        hist_pad_next = '0;
      end
      pressed_pad_next = btn_pad_next & ~btn_reg[gi];
    end

    assign btn_next[gi]     = btn_pad_next;
    assign pressed_next[gi] = pressed_pad_next;
    assign hist_next[gi]    = hist_pad_next;
  end

  // ---------------------------------------------------------------------------
  // Synchronizers, sequencer, sampling and publish.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock50) begin
    if (Reset) begin
      vs_meta_reg     <= 1'b0;
      vs_sync_reg     <= 1'b0;
      vs_prev_reg     <= 1'b0;
      pins_meta_reg   <= '0;
      pins_sync_reg   <= '0;
      state_reg       <= IDLE;
      phase_reg       <= 3'd0;
      cnt_reg         <= '0;
      force_reg       <= 1'b0;
      select_reg      <= 1'b1;
      busy_reg        <= 1'b0;
      raw_btn_reg     <= '0;
      raw_present_reg <= '0;
      raw_six_reg     <= '0;
      btn_reg         <= '0;
      pressed_reg     <= '0;
      present_reg     <= '0;
      six_reg         <= '0;
      valid_reg       <= 1'b0;
      hist_reg        <= '0;
    end else begin
      vs_meta_reg   <= v_sync;
      vs_sync_reg   <= vs_meta_reg;
      vs_prev_reg   <= vs_sync_reg;
      pins_meta_reg <= Pins;
      pins_sync_reg <= pins_meta_reg;

      valid_reg   <= 1'b0;
      pressed_reg <= '0;

      case (state_reg)
        IDLE: begin
          select_reg <= 1'b1;
          busy_reg   <= 1'b0;
          if (vs_fall) begin
            state_reg   <= SCAN;
            force_reg   <= ForceThree;
            phase_reg   <= 3'd0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            // Only phase 5 can set this; 3-button scans never reach it.
            raw_six_reg <= '0;
          end
        end

        SCAN: begin
          if (cnt_reg == LAST_COUNT) begin
            cnt_reg <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
              case (phase_reg)
                3'd0: raw_btn_reg[p][5:0] <= ~pins_sync_reg[p];
                3'd1: begin
                  raw_btn_reg[p][6]  <= ~pins_sync_reg[p][4];
                  raw_btn_reg[p][7]  <= ~pins_sync_reg[p][5];
                  raw_present_reg[p] <= ~pins_sync_reg[p][2] & ~pins_sync_reg[p][3];
                end
                3'd5: raw_six_reg[p] <= raw_present_reg[p] &
                                        (pins_sync_reg[p][3:0] == 4'b0000);
                3'd6: raw_btn_reg[p][11:8] <= ~pins_sync_reg[p][3:0];
                default: ;
              endcase
            end
            if (last_phase) begin
              state_reg  <= PUBLISH;
              busy_reg   <= 1'b0;
              select_reg <= 1'b1;
            end else begin
              phase_reg  <= phase_reg + 3'd1;
              // Next phase is even (Select high) when the current one is odd.
              select_reg <= phase_reg[0];
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        PUBLISH: begin
          btn_reg     <= btn_next;
          pressed_reg <= pressed_next;
          hist_reg    <= hist_next;
          present_reg <= raw_present_reg;
          six_reg     <= raw_six_reg;
          valid_reg   <= 1'b1;
          state_reg   <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Select    = select_reg;
  assign Busy      = busy_reg;
  assign Valid     = valid_reg;
  assign Buttons   = btn_reg;
  assign Pressed   = pressed_reg;
  assign Present   = present_reg;
  assign SixButton = six_reg;

endmodule

// File: tb/tb_gamepad_scanner.sv
// -----------------------------------------------------------------------------
// tb_gamepad_scanner
//
// Drives gamepad_scanner (2 pads, 4-cycle phases, 2-frame debounce) with a
// behavioural pad model that answers the Select line like 3- and 6-button
// controllers. Each table row configures the pads, queues the expected
// published result and triggers a scan; a monitor pops the queue on Valid.
// -----------------------------------------------------------------------------
module tb_gamepad_scanner;

  localparam int NUM_PADS = 2;

  logic                   clk = 1'b0;
  logic                   Reset;
  logic                   v_sync;
  logic [6*NUM_PADS-1:0]  Pins;
  logic                   ForceThree;
  logic                   Select;
  logic [12*NUM_PADS-1:0] Buttons;
  logic [12*NUM_PADS-1:0] Pressed;
  logic [NUM_PADS-1:0]    Present;
  logic [NUM_PADS-1:0]    SixButton;
  logic                   Valid;
  logic                   Busy;

  always #5 clk = ~clk;

  gamepad_scanner #(
    .NUM_PADS(2),
    .SETTLE_CYCLES(4),
    .DEBOUNCE_FRAMES(2)
  ) dut (
    .Clock50(clk),
    .Reset(Reset),
    .v_sync(v_sync),
    .Pins(Pins),
    .ForceThree(ForceThree),
    .Select(Select),
    .Buttons(Buttons),
    .Pressed(Pressed),
    .Present(Present),
    .SixButton(SixButton),
    .Valid(Valid),
    .Busy(Busy)
  );

  // ---------------------------------------------------------------------------
  // Pad model. low_cnt counts Select low pulses since Select was last high
  // for a long stretch; the 3rd low pulse and the following high phase carry
  // the 6-button extras.
  // ---------------------------------------------------------------------------
  logic [1:0]  pad_conn = 2'b00;
  logic [1:0]  pad_six  = 2'b00;
  logic [11:0] pad_btn0 = 12'h000;
  logic [11:0] pad_btn1 = 12'h000;
  logic [2:0]  low_cnt  = 3'd0;
  int          hi_cnt   = 0;
  logic        sel_d    = 1'b1;

  always @(posedge clk) begin
    sel_d  <= Select;
    hi_cnt <= Select ? ((hi_cnt < 100) ? hi_cnt + 1 : hi_cnt) : 0;
    if (sel_d && !Select) low_cnt <= low_cnt + 3'd1;
    else if (hi_cnt >= 6) low_cnt <= 3'd0;
  end

  // Returns active-low {P9,P6,P4,P3,P2,P1}.
  function automatic logic [5:0] pad_pins(input logic conn, input logic six,
                                          input logic [11:0] b, input logic sel,
                                          input logic [2:0] lc);
    logic [5:0] p;
    p = 6'h3F;
    if (conn) begin
      if (sel) begin
        if (six && lc == 3'd3) p[3:0] = ~b[11:8];
        else                   p[3:0] = ~b[3:0];
        p[4] = ~b[4];
        p[5] = ~b[5];
      end else begin
        if (six && lc == 3'd3)      p[3:0] = 4'b0000;
        else if (six && lc == 3'd4) p[3:0] = 4'b1111;
        else                        p[3:0] = {2'b00, ~b[1], ~b[0]};
        p[4] = ~b[6];
        p[5] = ~b[7];
      end
    end
    return p;
  endfunction

  always_comb begin
    Pins = {pad_pins(pad_conn[1], pad_six[1], pad_btn1, Select, low_cnt),
            pad_pins(pad_conn[0], pad_six[0], pad_btn0, Select, low_cnt)};
  end

  // ---------------------------------------------------------------------------
  // Vectors and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  conn;
    logic [1:0]  six;
    logic [11:0] btn0;
    logic [11:0] btn1;
    logic        force3;
    logic [23:0] exp_btn;
    logic [23:0] exp_prs;
    logic [1:0]  exp_pres;
    logic [1:0]  exp_six;
    int          exp_busy;
    int          exp_tog;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];
  vec_t sb_q[$];
  vec_t mon_e;
  vec_t tail_e;

  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   tog_cnt = 0;
  int   scan_no = 0;
  int   seen;
  logic sel_prev = 1'b1;
  bit   after_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_vsync();
    v_sync = 1'b0;
    repeat (4) @(negedge clk);
    v_sync = 1'b1;
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 150; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chk(name, sb_q.size(), 0);
    if (sb_q.size() != 0) sb_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    pad_conn   = v.conn;
    pad_six    = v.six;
    pad_btn0   = v.btn0;
    pad_btn1   = v.btn1;
    ForceThree = v.force3;
    sb_q.push_back(v);
    pulse_vsync();
    wait_drained("scan_done");
    ForceThree = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    // conn  six    btn0     btn1     f3    buttons      pressed      pres   six  busy tog
    tbl[0]  = '{2'b01, 2'b00, 12'h040, 12'h000, 1'b0, 24'h000000, 24'h000000, 2'b01, 2'b00, 32, 8};
    tbl[1]  = '{2'b01, 2'b00, 12'h040, 12'h000, 1'b0, 24'h000040, 24'h000040, 2'b01, 2'b00, 32, 8};
    tbl[2]  = '{2'b01, 2'b01, 12'h400, 12'h000, 1'b0, 24'h000040, 24'h000000, 2'b01, 2'b01, 32, 8};
    tbl[3]  = '{2'b01, 2'b01, 12'h400, 12'h000, 1'b0, 24'h000400, 24'h000400, 2'b01, 2'b01, 32, 8};
    tbl[4]  = '{2'b01, 2'b01, 12'h400, 12'h000, 1'b1, 24'h000400, 24'h000000, 2'b01, 2'b00,  8, 2};
    tbl[5]  = '{2'b01, 2'b01, 12'h400, 12'h000, 1'b1, 24'h000000, 24'h000000, 2'b01, 2'b00,  8, 2};
    tbl[6]  = '{2'b11, 2'b00, 12'h000, 12'h001, 1'b0, 24'h000000, 24'h000000, 2'b11, 2'b00, 32, 8};
    tbl[7]  = '{2'b11, 2'b00, 12'h000, 12'h000, 1'b0, 24'h000000, 24'h000000, 2'b11, 2'b00, 32, 8};
    tbl[8]  = '{2'b11, 2'b00, 12'h080, 12'h000, 1'b0, 24'h000000, 24'h000000, 2'b11, 2'b00, 32, 8};
    tbl[9]  = '{2'b11, 2'b00, 12'h080, 12'h000, 1'b0, 24'h000080, 24'h000080, 2'b11, 2'b00, 32, 8};
    tbl[10] = '{2'b10, 2'b00, 12'h080, 12'h000, 1'b0, 24'h000000, 24'h000000, 2'b10, 2'b00, 32, 8};
    tbl[11] = '{2'b11, 2'b00, 12'h080, 12'h000, 1'b0, 24'h000000, 24'h000000, 2'b11, 2'b00, 32, 8};
    tbl[12] = '{2'b11, 2'b00, 12'h080, 12'h018, 1'b0, 24'h000080, 24'h000080, 2'b11, 2'b00, 32, 8};
    tbl[13] = '{2'b11, 2'b00, 12'h080, 12'h018, 1'b0, 24'h018080, 24'h018000, 2'b11, 2'b00, 32, 8};

    Reset      = 1'b1;
    v_sync     = 1'b1;
    ForceThree = 1'b0;

    // Monitor: counts Busy cycles and Select toggles per scan, compares on Valid.
    fork
      forever begin
        @(negedge clk);
        if (Reset) begin
          busy_cnt    = 0;
          tog_cnt     = 0;
          sel_prev    = Select;
          after_valid = 1'b0;
        end else begin
          if (Busy) busy_cnt++;
          if (Select !== sel_prev) tog_cnt++;
          sel_prev = Select;
          if (after_valid) begin
            chk("valid_one_cycle", Valid, 1'b0);
            chk("pressed_one_cycle", Pressed, 24'h0);
            after_valid = 1'b0;
          end
          if (Valid) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid: Valid=1 with no scan pending, expected no publish");
            end else begin
              mon_e = sb_q.pop_front();
              scan_no++;
              $display("scan %0d: buttons=%h pressed=%h present=%b six=%b busy=%0d toggles=%0d",
                       scan_no, Buttons, Pressed, Present, SixButton, busy_cnt, tog_cnt);
              chk("buttons", Buttons, mon_e.exp_btn);
              chk("pressed", Pressed, mon_e.exp_prs);
              chk("present", Present, mon_e.exp_pres);
              chk("six_button", SixButton, mon_e.exp_six);
              chk("busy_cycles", busy_cnt, mon_e.exp_busy);
              chk("select_toggles", tog_cnt, mon_e.exp_tog);
            end
            busy_cnt    = 0;
            tog_cnt     = 0;
            after_valid = 1'b1;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_select", Select, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_valid", Valid, 1'b0);
    chk("rst_buttons", Buttons, 24'h0);
    chk("rst_pressed", Pressed, 24'h0);
    chk("rst_present", Present, 2'b00);
    chk("rst_six", SixButton, 2'b00);
    Reset = 1'b0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(tbl[i]);

    // A second v_sync edge mid-scan is ignored: exactly one publish, no rescan.
    tail_e         = tbl[13];
    tail_e.exp_prs = 24'h0;
    sb_q.push_back(tail_e);
    pulse_vsync();
    chk("busy_started", Busy, 1'b1);
    repeat (12) @(negedge clk);
    chk("select_phase3", Select, 1'b0);
    pulse_vsync();
    wait_drained("scan_done_ignored_edge");
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Busy) seen++;
    end
    chk("no_rescan_busy", seen, 0);

    // Reset in phase 5 aborts the scan without publishing.
    pulse_vsync();
    repeat (19) @(negedge clk);
    chk("select_phase5", Select, 1'b0);
    chk("busy_phase5", Busy, 1'b1);
    Reset = 1'b1;
    @(negedge clk);
    chk("abort_select", Select, 1'b1);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_valid", Valid, 1'b0);
    chk("abort_buttons", Buttons, 24'h0);
    chk("abort_pressed", Pressed, 24'h0);
    chk("abort_present", Present, 2'b00);
    chk("abort_six", SixButton, 2'b00);
    Reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Valid || Busy) seen++;
    end
    chk("abort_no_publish", seen, 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamepad_scanner.md
GAMEPAD_SCANNER -- requirements
Module: gamepad_scanner

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2, number of controller ports sharing one Select line (legal 1..4).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 500, Clock50 cycles per Select phase (legal >= 4).
REQ-003 SHALL have parameter DEBOUNCE_FRAMES, default 2, consecutive identical scans required before a button bit changes (legal 1..4; 1 = no filtering).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Clock50  input  1  system clock, all logic on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 v_sync  input  1  VGA vertical sync from the pixel domain, active-low; its falling edge starts a scan.
REQ-008 Pins  input  6*NUM_PADS  raw pad pins, active-low; pad p uses [6p+0]=Pino1, [6p+1]=Pino2, [6p+2]=Pino3, [6p+3]=Pino4, [6p+4]=Pino6, [6p+5]=Pino9.
REQ-009 ForceThree  input  1  when 1, the next scan runs in 3-button mode (phases 0-1 only).
REQ-010 Select  output  1  shared pad Select line.
REQ-011 Buttons  output  12*NUM_PADS  debounced, active-high button state; per pad bit 0 Up, 1 Down, 2 Left, 3 Right, 4 B, 5 C, 6 A, 7 Start, 8 Z, 9 Y, 10 X, 11 Mode.
REQ-012 Pressed  output  12*NUM_PADS  one-cycle pulse per bit on a debounced 0->1 transition.
REQ-013 Present  output  NUM_PADS  pad detected in the last scan.
REQ-014 SixButton  output  NUM_PADS  pad identified as 6-button in the last scan.
REQ-015 Valid  output  1  one-cycle pulse when a scan's results are published.
REQ-016 Busy  output  1  high while a scan is in progress.

Function
REQ-017 v_sync and Pins SHALL pass through a 2-flop synchronizer before use; v_sync falling edge is detected on the synchronized signal.
REQ-018 FSM states SHALL be IDLE, SCAN, PUBLISH; IDLE holds Select=1, Busy=0.
REQ-019 IDLE -> SCAN on a detected v_sync falling edge; ForceThree SHALL be latched on that edge and held for the whole scan; phase index=0, counter=0.
REQ-020 In SCAN, each phase SHALL last exactly SETTLE_CYCLES cycles; Select = 1 in even phases, 0 in odd phases; Busy=1.
REQ-021 Synchronized Pins SHALL be sampled in the last cycle of each phase (counter = SETTLE_CYCLES-1).
REQ-022 Phase 0 sample SHALL capture Up, Down, Left, Right, B, C from Pino1, Pino2, Pino3, Pino4, Pino6, Pino9.
REQ-023 Phase 1 sample SHALL capture A (Pino6) and Start (Pino9); Present[p] = Pino3 and Pino4 both low.
REQ-024 Phase 5 sample SHALL set SixButton[p] = Pino1-Pino4 all low, and only if Present[p].
REQ-025 Phase 6 sample SHALL capture Z, Y, X, Mode from Pino1-Pino4; these are used only when SixButton[p], else forced 0.
REQ-026 SCAN -> PUBLISH after phase 7 (normal mode) or phase 1 (ForceThree latched); SixButton = 0 in 3-button mode.
REQ-027 PUBLISH SHALL last one cycle then return to IDLE. On the edge leaving PUBLISH, Buttons, Pressed, Present, SixButton and Valid SHALL update together; Valid and Pressed are high for exactly that one cycle.
REQ-028 Debounce: per bit, the raw value SHALL be copied into Buttons only when the same value has been sampled in DEBOUNCE_FRAMES consecutive scans; otherwise Buttons holds.
REQ-029 An absent pad (Present=0) SHALL force its 12 Buttons bits to 0 immediately, bypassing debounce, and SHALL clear its debounce history.
REQ-030 A v_sync falling edge while Busy or in PUBLISH SHALL be ignored; no restart, no queuing.
REQ-031 Scan length SHALL be 8*SETTLE_CYCLES (normal) or 2*SETTLE_CYCLES (ForceThree) cycles, plus 1 PUBLISH cycle.

Reset
REQ-032 When Reset=1, the FSM SHALL go to IDLE, Select=1, Busy=0, Valid=0, and Buttons, Pressed, Present, SixButton, debounce history and synchronizers SHALL be 0. Reset mid-scan SHALL abort the scan with no publish.

Verification (NUM_PADS=2, SETTLE_CYCLES=4, DEBOUNCE_FRAMES=2)
REQ-033 3-button pad on pad 0 with A held, pad 1 all pins high, two scans -> after scan 2: Buttons[6]=1, Pressed[6]=1 for one cycle, Present=2'b01, SixButton=2'b00, Valid pulses once per scan.
REQ-034 6-button model on pad 0 with X held -> Select toggles 8 times, 4 cycles per phase; Busy high for 32 cycles; SixButton[0]=1; Buttons[10]=1 after the 2nd scan.
REQ-035 ForceThree=1 with a 6-button pad -> Busy high for 8 cycles; SixButton=0; Buttons[11:8]=0.
REQ-036 Single-scan glitch on pad 1 Up, then released -> Buttons[12] stays 0 and Pressed[12] never pulses.
REQ-037 Second v_sync falling edge at phase 3, then Reset asserted at phase 5 of the next scan -> first event ignored; after reset, Select=1, all outputs 0, no Valid pulse.
REQ-038 Pad 0 unplugged (all pins high) while Start is debounced 1 -> at the next publish, Present[0]=0 and Buttons[11:0]=0.
